// File: rtl/receptor_salida_pkg.sv
// Shared types and constants for the output-side drain of the 4x4 FIFO switch.
package receptor_salida_pkg;

    localparam int unsigned DATA_WIDTH = 10;
    localparam int unsigned CNT_WIDTH  = 5;
    localparam int unsigned N_PORTS    = 4;
    localparam int unsigned PORT_WIDTH = 2;
    localparam int unsigned DEST_MSB   = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    // Index of the set bit in a one-hot port vector (0 when none set).
    function automatic logic [PORT_WIDTH-1:0] onehot_to_idx(input logic [N_PORTS-1:0] oh);
        logic [PORT_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (oh[i]) r = PORT_WIDTH'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/receptor_salida_rr_selector.sv
// Combinational round-robin pick: first requesting, non-excluded port at or above ptr (mod 4).
module receptor_salida_rr_selector
    import receptor_salida_pkg::*;
(
    input  logic [N_PORTS-1:0]    req_mask,
    input  logic [N_PORTS-1:0]    excl_mask,
    input  logic [PORT_WIDTH-1:0] ptr,
    output logic [N_PORTS-1:0]    grant,
    output logic                  grant_valid
);

    logic [N_PORTS-1:0]    cand;
    logic [PORT_WIDTH-1:0] pos;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        pos         = '0;
        cand        = req_mask & ~excl_mask;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            pos = ptr + PORT_WIDTH'(i);
            if (!grant_valid && cand[pos]) begin
                grant[pos]  = 1'b1;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/receptor_salida.sv
// Drains output FIFOs 4..7 round-robin, checks destinations and keeps queryable per-port receive counts.
module receptor_salida
    import receptor_salida_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [N_PORTS-1:0]    empty_out,
    input  logic [DATA_WIDTH-1:0] FIFO_data_out4,
    input  logic [DATA_WIDTH-1:0] FIFO_data_out5,
    input  logic [DATA_WIDTH-1:0] FIFO_data_out6,
    input  logic [DATA_WIDTH-1:0] FIFO_data_out7,
    output logic                  pop4,
    output logic                  pop5,
    output logic                  pop6,
    output logic                  pop7,
    output logic [DATA_WIDTH-1:0] data_rx,
    output logic                  data_rx_valid,
    output logic [PORT_WIDTH-1:0] port_rx,
    output logic                  dest_err,
    output logic [CNT_WIDTH-1:0]  err_count,
    input  logic [PORT_WIDTH-1:0] idx,
    input  logic                  req,
    output logic                  valid_contador,
    output logic [CNT_WIDTH-1:0]  contador_out
);

    state_t                state, state_nxt;
    logic                  sel_en;
    logic [N_PORTS-1:0]    pop_q;
    logic [N_PORTS-1:0]    grant;
    logic                  grant_valid;
    logic [PORT_WIDTH-1:0] ptr;
    logic [PORT_WIDTH-1:0] grant_idx;
    logic [PORT_WIDTH-1:0] cap_port;
    logic [DATA_WIDTH-1:0] cap_data;
    logic                  cap_hit;
    logic                  cap_bad;
    logic [CNT_WIDTH-1:0]  cnt [N_PORTS];

    assign {pop7, pop6, pop5, pop4} = pop_q;

    // The port popped this cycle is masked so its stale empty flag cannot re-select it.
    receptor_salida_rr_selector u_rr_selector (
        .req_mask    (~empty_out),
        .excl_mask   (pop_q),
        .ptr         (ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign grant_idx = onehot_to_idx(grant);
    assign cap_port  = onehot_to_idx(pop_q);
    assign cap_hit   = |pop_q;
    assign cap_bad   = cap_data[DEST_MSB -: PORT_WIDTH] != cap_port;

    always_comb begin
        unique case (cap_port)
            2'd0:    cap_data = FIFO_data_out4;
            2'd1:    cap_data = FIFO_data_out5;
            2'd2:    cap_data = FIFO_data_out6;
            default: cap_data = FIFO_data_out7;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_RST;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sel_en    = 1'b0;
        unique case (state)
            ST_RST:  state_nxt = ST_HOLD;
            ST_HOLD: begin
                sel_en = enable;
                if (enable) state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                sel_en = enable;
                if (!enable) state_nxt = ST_HOLD;
            end
            default: state_nxt = ST_RST;
        endcase
    end

    // Pop issue, capture of the previously popped word, counters and query port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pop_q          <= '0;
            ptr            <= '0;
            data_rx        <= '0;
            data_rx_valid  <= 1'b0;
            port_rx        <= '0;
            dest_err       <= 1'b0;
            err_count      <= '0;
            valid_contador <= 1'b0;
            contador_out   <= '0;
            for (int i = 0; i < int'(N_PORTS); i++) cnt[i] <= '0;
        end else begin
            pop_q <= (sel_en && grant_valid) ? grant : '0;
            if (sel_en && grant_valid) ptr <= grant_idx + PORT_WIDTH'(1);

            data_rx_valid <= cap_hit;
            dest_err      <= cap_hit && cap_bad;
            if (cap_hit) begin
                data_rx <= cap_data;
                port_rx <= cap_port;
                if (cnt[cap_port] != '1) cnt[cap_port] <= cnt[cap_port] + CNT_WIDTH'(1);
                if (cap_bad && err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
            end

            // Reads the pre-increment count when a capture hits the same port.
            valid_contador <= req;
            if (req) contador_out <= cnt[idx];
        end
    end

endmodule

// File: tb/tb_receptor_salida.sv
// Self-checking bench for receptor_salida: FIFO models, a behavioural reference model and scenario tasks.
module tb_receptor_salida;

    localparam int DW  = 10;
    localparam int CW  = 5;
    localparam int SAT = 31;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          req = 1'b0;
    logic [1:0]    idx = 2'd0;
    logic [3:0]    empty_v = 4'hF;
    logic [DW-1:0] data_v [4] = '{default: '0};

    logic          pop4, pop5, pop6, pop7;
    logic [DW-1:0] data_rx;
    logic          data_rx_valid;
    logic [1:0]    port_rx;
    logic          dest_err;
    logic [CW-1:0] err_count;
    logic          valid_contador;
    logic [CW-1:0] contador_out;
    logic [3:0]    pops;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] fq [4][$];

    // Reference model state: predicted pop, pointer, counts and expected outputs.
    int            m_pop = -1;
    int            m_ptr = 0;
    int            m_cnt [4] = '{default: 0};
    int            m_err = 0;
    bit            m_in_rst = 1'b1;
    logic [DW-1:0] e_data = '0;
    int            e_port = 0;
    bit            e_valid = 1'b0;
    bit            e_derr = 1'b0;
    bit            e_vc = 1'b0;
    int            e_co = 0;

    receptor_salida dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .empty_out      (empty_v),
        .FIFO_data_out4 (data_v[0]),
        .FIFO_data_out5 (data_v[1]),
        .FIFO_data_out6 (data_v[2]),
        .FIFO_data_out7 (data_v[3]),
        .pop4           (pop4),
        .pop5           (pop5),
        .pop6           (pop6),
        .pop7           (pop7),
        .data_rx        (data_rx),
        .data_rx_valid  (data_rx_valid),
        .port_rx        (port_rx),
        .dest_err       (dest_err),
        .err_count      (err_count),
        .idx            (idx),
        .req            (req),
        .valid_contador (valid_contador),
        .contador_out   (contador_out)
    );

    assign pops = {pop7, pop6, pop5, pop4};

    always #5 clk = ~clk;

    function automatic logic [3:0] pvec(input int p);
        logic [3:0] v;
        v = 4'h0;
        if (p >= 0) v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] mkword(input int dest);
        logic [7:0] payload;
        payload = 8'($urandom);
        return {2'(dest), payload};
    endfunction

    // Model step plus show-ahead FIFO behaviour, evaluated on every rising edge.
    always @(posedge clk) begin
        int            np;
        int            p;
        logic [DW-1:0] w;
        if (!reset) begin
            m_pop = -1; m_ptr = 0; m_err = 0; m_in_rst = 1'b1;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            e_data = '0; e_port = 0; e_valid = 1'b0; e_derr = 1'b0; e_vc = 1'b0; e_co = 0;
        end else begin
            e_vc = req;
            if (req) e_co = m_cnt[idx];
            e_valid = 1'b0;
            e_derr  = 1'b0;
            if (m_pop >= 0) begin
                w = (fq[m_pop].size() > 0) ? fq[m_pop][0] : data_v[m_pop];
                e_data  = w;
                e_port  = m_pop;
                e_valid = 1'b1;
                if (m_cnt[m_pop] < SAT) m_cnt[m_pop]++;
                if (int'(w[DW-1:DW-2]) != m_pop) begin
                    e_derr = 1'b1;
                    if (m_err < SAT) m_err++;
                end
            end
            np = -1;
            if (enable && !m_in_rst) begin
                for (int k = 0; k < 4; k++) begin
                    p = (m_ptr + k) % 4;
                    if (np < 0 && !empty_v[p] && p != m_pop) np = p;
                end
            end
            if (np >= 0) m_ptr = (np + 1) % 4;
            m_pop    = np;
            m_in_rst = 1'b0;
        end
        for (int i = 0; i < 4; i++)
            if (pops[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        for (int i = 0; i < 4; i++) begin
            empty_v[i] <= (fq[i].size() == 0);
            data_v[i]  <= (fq[i].size() > 0) ? fq[i][0] : '0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; enable = 1'b0; req = 1'b0;
        for (int i = 0; i < 4; i++) fq[i].delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_pop(input logic [3:0] mask, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if ((pops & mask) != 4'h0) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({pops, data_rx_valid, data_rx, port_rx, dest_err, err_count, valid_contador, contador_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: pops=%h v=%b d=%h p=%0d e=%b ec=%0d vc=%b co=%0d, all must be 0",
                     pops, data_rx_valid, data_rx, port_rx, dest_err, err_count, valid_contador, contador_out);
        end
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 4; p++) fq[p].push_back(mkword(p));
        wait_pop(4'hF, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rr_start: no pop within 20 cycles, expected pop4"); end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (pops !== pvec(k % 4)) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: pops=%b expected %b", k, pops, pvec(k % 4));
            end
            if (data_rx_valid) begin
                n_tests++;
                if (data_rx !== e_data || port_rx !== 2'(e_port)) begin
                    n_fail++;
                    $display("FAIL rr_data: data=%h port=%0d expected %h port %0d", data_rx, port_rx, e_data, e_port);
                end
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            req = 1'b1; idx = 2'(p);
            @(negedge clk);
            n_tests++;
            if (valid_contador !== 1'b1 || contador_out !== 5'd2) begin
                n_fail++;
                $display("FAIL rr_count[%0d]: valid=%b count=%0d expected valid 1 count 2", p, valid_contador, contador_out);
            end
        end
        req = 1'b0;
        n_tests++;
        if (err_count !== 5'd0) begin n_fail++; $display("FAIL rr_errcount: %0d expected 0", err_count); end
    endtask

    task automatic test_single_port();
        logic [DW-1:0] words [3];
        int n_pop, n_cap, last_pop;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin words[k] = mkword(2); fq[2].push_back(words[k]); end
        n_pop = 0; n_cap = 0; last_pop = -10;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (pops !== 4'h0) begin
                n_tests++;
                if (pops !== 4'b0100 || (n_pop > 0 && c - last_pop != 2)) begin
                    n_fail++;
                    $display("FAIL single_pop: cycle %0d pops=%b gap=%0d expected pop6 with gap 2", c, pops, c - last_pop);
                end
                last_pop = c; n_pop++;
            end
            if (data_rx_valid) begin
                n_tests++;
                if (port_rx !== 2'd2 || n_cap > 2 || data_rx !== words[n_cap > 2 ? 2 : n_cap]) begin
                    n_fail++;
                    $display("FAIL single_cap: port=%0d data=%h capture #%0d", port_rx, data_rx, n_cap);
                end
                n_cap++;
            end
        end
        n_tests++;
        if (n_pop != 3 || n_cap != 3) begin
            n_fail++;
            $display("FAIL single_totals: pops=%0d captures=%0d expected 3 and 3", n_pop, n_cap);
        end
        req = 1'b1; idx = 2'd2;
        @(negedge clk);
        req = 1'b0;
        n_tests++;
        if (valid_contador !== 1'b1 || contador_out !== 5'd3) begin
            n_fail++;
            $display("FAIL single_count: valid=%b count=%0d expected 1, 3", valid_contador, contador_out);
        end
    endtask

    task automatic test_dest_err();
        bit ok;
        do_reset();
        enable = 1'b1;
        fq[1].push_back(10'h3A5);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (data_rx_valid) ok = 1'b1;
            else @(negedge clk);
        end
        n_tests++;
        if (!ok || dest_err !== 1'b1 || port_rx !== 2'd1 || data_rx !== 10'h3A5 || err_count !== 5'd1) begin
            n_fail++;
            $display("FAIL dest_err: seen=%b derr=%b port=%0d data=%h errcnt=%0d expected 1,1,3a5,1",
                     ok, dest_err, port_rx, data_rx, err_count);
        end
        @(negedge clk);
        n_tests++;
        if (dest_err !== 1'b0 || err_count !== 5'd1) begin
            n_fail++;
            $display("FAIL dest_err_pulse: derr=%b errcnt=%0d expected 0 and 1", dest_err, err_count);
        end
    endtask

    task automatic test_query_collision();
        bit ok;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 4; k++) fq[0].push_back(mkword(0));
        repeat (12) @(negedge clk);
        fq[0].push_back(mkword(0));
        wait_pop(4'b0001, ok);
        req = 1'b1; idx = 2'd0;
        @(negedge clk);
        req = 1'b0;
        n_tests++;
        if (!ok || valid_contador !== 1'b1 || contador_out !== 5'd4) begin
            n_fail++;
            $display("FAIL collision_pre: popseen=%b valid=%b count=%0d expected 1, 4", ok, valid_contador, contador_out);
        end
        @(negedge clk);
        n_tests++;
        if (valid_contador !== 1'b0 || contador_out !== 5'd4) begin
            n_fail++;
            $display("FAIL collision_hold: valid=%b count=%0d expected 0, 4", valid_contador, contador_out);
        end
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n_tests++;
        if (valid_contador !== 1'b1 || contador_out !== 5'd5) begin
            n_fail++;
            $display("FAIL collision_post: valid=%b count=%0d expected 1, 5", valid_contador, contador_out);
        end
    endtask

    task automatic test_saturation_enable();
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 35; k++) fq[3].push_back(mkword(3));
        repeat (80) @(negedge clk);
        req = 1'b1; idx = 2'd3;
        @(negedge clk);
        req = 1'b0;
        n_tests++;
        if (valid_contador !== 1'b1 || contador_out !== 5'd31) begin
            n_fail++;
            $display("FAIL saturate: valid=%b count=%0d expected 1, 31", valid_contador, contador_out);
        end
        enable = 1'b0;
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 3; k++) fq[p].push_back(mkword(p));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tests++;
            if (pops !== 4'h0 || data_rx_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_nopop: cycle %0d pops=%b valid=%b expected none", c, pops, data_rx_valid);
            end
        end
        for (int p = 0; p < 4; p++) begin
            req = 1'b1; idx = 2'(p);
            @(negedge clk);
            n_tests++;
            if (contador_out !== ((p == 3) ? 5'd31 : 5'd0)) begin
                n_fail++;
                $display("FAIL hold_count[%0d]: count=%0d expected %0d", p, contador_out, (p == 3) ? 31 : 0);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_reset_midstream();
        bit ok;
        do_reset();
        enable = 1'b1;
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 6; k++) fq[p].push_back(mkword(p));
        wait_pop(4'hF, ok);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_tests++;
        if (!ok || {pops, data_rx_valid, data_rx, port_rx, dest_err, err_count, valid_contador, contador_out} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: popseen=%b pops=%h v=%b d=%h p=%0d e=%b ec=%0d vc=%b co=%0d",
                     ok, pops, data_rx_valid, data_rx, port_rx, dest_err, err_count, valid_contador, contador_out);
        end
        req = 1'b1; idx = 2'($urandom);
        @(negedge clk);
        req = 1'b0;
        n_tests++;
        if (pops !== 4'h0 || data_rx_valid !== 1'b0 || contador_out !== 5'd0) begin
            n_fail++;
            $display("FAIL midreset_after: pops=%b valid=%b count=%0d expected 0,0,0", pops, data_rx_valid, contador_out);
        end
        @(negedge clk);
        n_tests++;
        if (pops !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_ptr: pops=%b expected 0001", pops);
        end
    endtask

    task automatic test_random();
        int nprint;
        do_reset();
        nprint = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_tests++;
            if (pops !== pvec(m_pop)
                || {data_rx_valid, data_rx, port_rx, dest_err} !== {e_valid, e_data, 2'(e_port), e_derr}
                || err_count !== 5'(m_err)
                || {valid_contador, contador_out} !== {e_vc, 5'(e_co)}) begin
                n_fail++;
                if (nprint < 10) begin
                    nprint++;
                    $display("FAIL random[%0d]: pops=%b/%b v=%b/%b d=%h/%h p=%0d/%0d e=%b/%b ec=%0d/%0d vc=%b/%b co=%0d/%0d",
                             c, pops, pvec(m_pop), data_rx_valid, e_valid, data_rx, e_data, port_rx, e_port,
                             dest_err, e_derr, err_count, m_err, valid_contador, e_vc, contador_out, e_co);
                end
            end
            reset  = ($urandom_range(0, 199) != 0);
            enable = ($urandom_range(0, 7) != 0);
            req    = $urandom_range(0, 1) == 1;
            idx    = 2'($urandom);
            for (int p = 0; p < 4; p++) begin
                if ($urandom_range(0, 2) == 0 && fq[p].size() < 6)
                    fq[p].push_back(mkword(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : p));
            end
        end
        reset = 1'b1; enable = 1'b0; req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_port();
        test_dest_err();
        test_query_collision();
        test_saturation_enable();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete within 500000 time units");
        $fatal(1);
    end

endmodule

// File: doc/receptor_salida.md
# receptor_salida

Drain side of the 4x4 FIFO switch. The block watches the empty flags of output FIFOs 4–7 and pops them in round-robin order. It captures each popped word, checks its destination field against the FIFO it came from, and keeps a saturating per-port receive count. The count can be queried by index with the same req/idx/valid handshake the input-side pop counter uses, so a bench or top level can compare words sent against words received per destination.

## Interface
- data_width, 10, word width; bits [data_width-1:data_width-2] carry destination 0–3
- cnt_width, 5, per-port receive counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  1 = drain FIFOs; 0 = hold, no pops
- empty_out  in  4  empty flags of output FIFOs 4..7 (bit0 = FIFO4)
- FIFO_data_out4..7  in  data_width each  FIFO read data, valid the cycle after pop
- pop4..pop7  out  1 each  single-cycle pop strobes
- data_rx  out  data_width  last captured word
- data_rx_valid  out  1  one-cycle pulse with data_rx
- port_rx  out  2  FIFO index (0–3) data_rx came from
- dest_err  out  1  one-cycle pulse: captured destination ≠ port_rx
- err_count  out  cnt_width  saturating destination-error count
- idx  in  2  port to query
- req  in  1  query strobe
- valid_contador  out  1  query response valid
- contador_out  out  cnt_width  receive count of port idx

## Operation
- Reset (reset=0 at a clk edge) drives all of these to 0:
  - pops, data_rx, data_rx_valid, port_rx, dest_err, err_count, valid_contador, contador_out
  - the four counters
  - the pop-pending flag
  - the RR pointer (pointer = 0)
- FSM states:
  - RST: entered on reset; goes to HOLD on the first cycle with reset=1.
  - HOLD: enable=0; no pops. An already-issued pop is still captured.
  - SCAN: enable=1; each cycle, selects the first non-empty port searching from the RR pointer upward mod 4.
- Pop rule:
  - At most one pop per cycle.
  - The port popped in cycle t is excluded from selection in cycle t+1; this covers the empty-flag update lag.
  - After a pop of port p, the pointer becomes p+1 mod 4.
  - If all ports are empty or excluded, no pop is issued and the pointer is unchanged.
- Capture: if port p was popped in cycle t, then in cycle t+1:
  - data_rx = FIFO_data_out(p), port_rx = p, data_rx_valid = 1.
  - The counter for p increments, saturating at 2^cnt_width−1.
  - If data[data_width-1:data_width-2] ≠ p: dest_err = 1 and err_count increments (saturating).
- enable falling: no new pop that cycle; the pending capture still completes.
- Query: req=1 in cycle t gives valid_contador=1 and contador_out=count[idx] in cycle t+1.
  - The value is the count before any increment in cycle t.
  - Otherwise valid_contador=0 and contador_out holds its last value.
  - Queries are allowed in any state.
- A capture and a query of the same port in the same cycle: the query returns the pre-increment value.

## Timing
- Pop-to-data_rx_valid latency: 1 cycle.
- Query latency: 1 cycle.
- Throughput: 1 word/cycle with ≥2 non-empty ports; 1 word per 2 cycles with a single non-empty port.
- A pop asserted in the same cycle reset is low does not produce a capture.
- Outputs are registered; pops are registered from the selection made in the previous cycle's flags.

## Structure
- Shared package holds:
  - FSM state encoding (RST, HOLD, SCAN)
  - DEST_MSB = data_width-1
  - N_PORTS = 4
- One natural sub-module: rr_selector. It is combinational: inputs are request mask, exclude mask and pointer; outputs are a one-hot grant and a valid bit. The FSM, capture registers and counters stay in receptor_salida.

## Test plan
- Reset mid-stream: reset=0 for 1 cycle while popping -> next cycle all outputs 0, counters 0, pointer 0, no data_rx_valid.
- Round-robin: all four FIFOs hold 2 words each with correct destinations -> pops in order 4,5,6,7,4,5,6,7 on consecutive cycles; all counters = 2; err_count = 0.
- Single port: only FIFO6 holds 3 words -> pop6 asserted every other cycle; three data_rx_valid pulses with port_rx = 2; count[2] = 3.
- Destination error: FIFO5 word = 10'h3A5 (destination 3) -> dest_err pulse with port_rx = 1; err_count = 1.
- Query collision: count[0] = 4; capture from FIFO4 and req with idx=0 in the same cycle -> contador_out = 4 with valid_contador = 1; a later query returns 5.
- Saturation and enable: 35 words into FIFO7 -> contador_out = 31. With enable=0 while FIFOs are non-empty, no pops occur and counts stay unchanged.
